// File: rtl/led_activity_driver_pkg.sv
// Shared definitions for the LED activity driver.
// Contents:
//   led_state_e : per-channel blink state encoding (IDLE / ON / GAP). Code 2'd3 is unused
//                 and is treated as IDLE by the channel FSM.
//   max_int     : elaboration-time maximum, used to size the shared on/gap counter.
package led_activity_driver_pkg;

  typedef enum logic [1:0] {
    LED_IDLE = 2'd0,
    LED_ON   = 2'd1,
    LED_GAP  = 2'd2
  } led_state_e;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/led_activity_driver_stretch_ch.sv
// One LED channel: turns single-cycle activity strobes into a fixed-length blink followed by
// a fixed minimum dark gap. At most one strobe is remembered while a blink/gap is running.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   evt     in   activity strobe, sampled every clock edge
//   active  out  1 while the channel is in its ON (blink) state
module led_activity_driver_stretch_ch
  import led_activity_driver_pkg::*;
#(
  parameter int STRETCH_CYCLES = 2500000,
  parameter int GAP_CYCLES     = 1250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic evt,
  output logic active
);

  // One counter serves both ON and GAP, so it is sized for the longer of the two.
  localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  led_state_e       state_r;
  led_state_e       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             pending_r;
  logic             pending_s;

  // State, counter and pending-strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= LED_IDLE;
      cnt_r     <= CNT_ZERO;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pending_r <= pending_s;
    end
  end

  // Next-state logic: ON and GAP each count down to zero from (length-1).
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pending_s = pending_r;
    case (state_r)
      LED_IDLE: begin
        if (evt) begin
          state_s = LED_ON;
          cnt_s   = STRETCH_LOAD;
        end else begin
          state_s = LED_IDLE;
        end
      end
      LED_ON: begin
        // pending is a single flag, so repeated strobes collapse into one.
        if (evt) begin
          pending_s = 1'b1;
        end else begin
          pending_s = pending_r;
        end
        if (cnt_r == CNT_ZERO) begin
          state_s = LED_GAP;
          cnt_s   = GAP_LOAD;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      LED_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          // A strobe arriving in the last gap cycle restarts the blink with no IDLE cycle.
          if (pending_r | evt) begin
            state_s = LED_ON;
            cnt_s   = STRETCH_LOAD;
          end else begin
            state_s = LED_IDLE;
          end
          pending_s = 1'b0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
          if (evt) begin
            pending_s = 1'b1;
          end else begin
            pending_s = pending_r;
          end
        end
      end
      default: begin
        state_s   = LED_IDLE;
        cnt_s     = CNT_ZERO;
        pending_s = 1'b0;
      end
    endcase
  end

  assign active = (state_r == LED_ON);

endmodule

// File: rtl/led_activity_driver.sv
// LED activity driver: generates the anode drive for N_CH decoupled LED indicators from
// single-cycle core status strobes, with fixed blink length, minimum dark gap, global PWM
// dimming and a lamp-test override.
// Ports:
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset (also forces LED_A dark immediately)
//   EVENT      in   per-channel activity strobe
//   BRIGHT     in   global brightness, 0 = dark, all-ones = always on
//   LAMP_TEST  in   force every LED fully on (does not disturb channel state)
//   LED_A      out  anode drive, 1 = lit
//   ACTIVE     out  per-channel blink state, not PWM-masked
module led_activity_driver
  import led_activity_driver_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int STRETCH_CYCLES = 2500000,
  parameter int GAP_CYCLES     = 1250000,
  parameter int PWM_BITS       = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_CH-1:0]     EVENT,
  input  logic [PWM_BITS-1:0] BRIGHT,
  input  logic                LAMP_TEST,
  output logic [N_CH-1:0]     LED_A,
  output logic [N_CH-1:0]     ACTIVE
);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                pwm_on_s;

  // Free-running PWM phase counter shared by all channels.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt_r <= {PWM_BITS{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
    end
  end

  // Full scale is special-cased so all-ones means 100% rather than (2**N-1)/2**N.
  assign pwm_on_s = (BRIGHT == {PWM_BITS{1'b1}}) | (pwm_cnt_r < BRIGHT);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_activity_driver_stretch_ch #(
      .STRETCH_CYCLES(STRETCH_CYCLES),
      .GAP_CYCLES    (GAP_CYCLES)
    ) u_ch (
      .clk   (CLK),
      .rst_n (RST_N),
      .evt   (EVENT[i]),
      .active(ACTIVE[i])
    );
  end

  // RST_N gates the drive directly so the LEDs go dark the instant reset asserts,
  // even while LAMP_TEST is held.
  assign LED_A = {N_CH{RST_N}} & ({N_CH{LAMP_TEST}} | (ACTIVE & {N_CH{pwm_on_s}}));

endmodule

// File: tb/tb_led_activity_driver.sv
// Self-checking bench for led_activity_driver. Two instances share all inputs:
// dut_a (STRETCH=4, GAP=2) and dut_b (STRETCH=32, GAP=2). A behavioural model tracks the
// remaining ON/GAP time per channel and the PWM phase; a compare process checks both
// instances on every falling edge, and directed sequences pin the model with literals.
module tb_led_activity_driver;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ev = 4'h0;
  logic [3:0] bright = 4'hF;
  logic       lamp = 1'b0;
  logic [3:0] led_a_a, act_a, led_a_b, act_b;

  int n_total = 0;
  int n_pass  = 0;

  led_activity_driver #(.N_CH(4), .STRETCH_CYCLES(4), .GAP_CYCLES(2), .PWM_BITS(4)) dut_a (
    .CLK(clk), .RST_N(rst_n), .EVENT(ev), .BRIGHT(bright), .LAMP_TEST(lamp),
    .LED_A(led_a_a), .ACTIVE(act_a)
  );

  led_activity_driver #(.N_CH(4), .STRETCH_CYCLES(32), .GAP_CYCLES(2), .PWM_BITS(4)) dut_b (
    .CLK(clk), .RST_N(rst_n), .EVENT(ev), .BRIGHT(bright), .LAMP_TEST(lamp),
    .LED_A(led_a_b), .ACTIVE(act_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_on[2][4];    // ON cycles still to come (0 = not blinking)
  int m_gap[2][4];   // GAP cycles still to come
  bit m_pend[2][4];
  int m_pwm = 0;

  function automatic int str_of(input int k);
    return (k == 0) ? 4 : 32;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        m_on[k][c] = 0; m_gap[k][c] = 0; m_pend[k][c] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pwm <= 0;
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin
          m_on[k][c] <= 0; m_gap[k][c] <= 0; m_pend[k][c] <= 1'b0;
        end
      end
    end else begin
      m_pwm <= (m_pwm + 1) % 16;
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin
          if (m_on[k][c] > 0) begin
            if (ev[c]) m_pend[k][c] <= 1'b1;
            if (m_on[k][c] == 1) begin
              m_on[k][c] <= 0; m_gap[k][c] <= GAP;
            end else begin
              m_on[k][c] <= m_on[k][c] - 1;
            end
          end else if (m_gap[k][c] > 0) begin
            if (m_gap[k][c] == 1) begin
              m_gap[k][c] <= 0;
              if (m_pend[k][c] || ev[c]) m_on[k][c] <= str_of(k);
              m_pend[k][c] <= 1'b0;
            end else begin
              m_gap[k][c] <= m_gap[k][c] - 1;
              if (ev[c]) m_pend[k][c] <= 1'b1;
            end
          end else if (ev[c]) begin
            m_on[k][c] <= str_of(k);
          end
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    logic [3:0] ea, el, aa, al;
    logic       pwm_on;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) ea[c] = (m_on[k][c] > 0);
      pwm_on = (bright == 4'hF) || (m_pwm < int'(bright));
      el = !rst_n ? 4'h0 : (lamp ? 4'hF : (ea & {4{pwm_on}}));
      aa = (k == 0) ? act_a : act_b;
      al = (k == 0) ? led_a_a : led_a_b;
      check($sformatf("active_dut%0d", k), {28'd0, aa}, {28'd0, ea});
      check($sformatf("led_a_dut%0d", k), {28'd0, al}, {28'd0, el});
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive a strobe vector 2 time units after a rising edge; it is sampled at the next edge.
  task automatic cyc(input logic [3:0] e);
    @(posedge clk);
    #2;
    ev = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0);
  endtask

  // Pulse channel ch on dut_a, then record ACTIVE[ch] for n cycles; extra strobes at steps a/b.
  task automatic pattern(input string nm, input int ch, input int n, input int a, input int b,
                         input logic [31:0] exp);
    logic [31:0] s;
    logic [3:0]  oh;
    s  = 32'd0;
    oh = 4'b0001 << ch;
    cyc(oh);
    for (int i = 0; i < n; i++) begin
      cyc((i == a || i == b) ? oh : 4'h0);
      #1;
      s[i] = act_a[ch];
    end
    check(nm, s, exp);
  endtask

  initial begin
    int lit;
    int on;
    logic [3:0] others;

    idle(3);
    #1;
    check("reset_led_a", {28'd0, led_a_a}, 32'd0);
    check("reset_active", {28'd0, act_a}, 32'd0);
    rst_n = 1'b1;
    idle(4);

    // 1: single blink, other channels untouched.
    others = 4'h0;
    cyc(4'b0001);
    lit = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(4'h0);
      #1;
      others = others | act_a[3:1] | led_a_a[3:1];
      lit = lit + int'(led_a_a[0]);
    end
    check("t1_other_ch", {28'd0, others}, 32'd0);
    check("t1_lit_cycles", lit, 32'd4);
    idle(4);
    pattern("t1_blink", 0, 8, -1, -1, 32'h0000_000F);
    idle(4);

    // 2: second strobe pends, third dropped.
    pattern("t2_pend_drop", 0, 14, 1, 2, 32'h0000_03CF);
    idle(4);

    // 3: strobe in final GAP cycle restarts with no IDLE cycle.
    pattern("t3_last_gap", 1, 13, 5, -1, 32'h0000_03CF);
    idle(4);

    // 4: PWM dimming on the 32-cycle instance.
    bright = 4'd4;
    cyc(4'b0100);
    lit = 0; on = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'h0); #1;
      on  = on + int'(act_b[2]);
      lit = lit + int'(led_a_b[2]);
    end
    check("t4_on_b4", on, 32'd32);
    check("t4_lit_b4", lit, 32'd8);
    bright = 4'd0;
    cyc(4'b0100);
    lit = 0; on = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'h0); #1;
      on  = on + int'(act_b[2]);
      lit = lit + int'(led_a_b[2]);
    end
    check("t4_on_b0", on, 32'd32);
    check("t4_lit_b0", lit, 32'd0);
    bright = 4'hF;
    idle(4);

    // 5: async reset mid-ON with a pending strobe, LAMP_TEST held.
    cyc(4'b0001);
    cyc(4'b0001);
    cyc(4'h0);
    #1;
    lamp  = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_async_led_a", {24'd0, led_a_b, led_a_a}, 32'd0);
    check("t5_async_active", {24'd0, act_b, act_a}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    lamp  = 1'b0;
    on = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(4'h0); #1;
      on = on + int'(act_a[0]) + int'(act_b[0]);
    end
    check("t5_no_stale", on, 32'd0);

    // 6: lamp test.
    lamp = 1'b1;
    idle(3);
    #1;
    check("t6_lamp_led_a", {28'd0, led_a_a}, 32'h0000_000F);
    check("t6_lamp_active", {28'd0, act_a}, 32'd0);
    pattern("t6_lamp_blink", 3, 8, -1, -1, 32'h0000_000F);
    lamp = 1'b0;
    idle(4);

    // Randomized traffic, checked by the compare process.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] e;
      for (int c = 0; c < 4; c++) e[c] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) bright = 4'($urandom_range(0, 15));
      lamp = ($urandom_range(0, 19) == 0);
      cyc(e);
      if (i == 200) begin
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
